change_dispenser: RTL and testbench



---
 rtl/change_dispenser.sv | 199 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: all-or-nothing payout of a change amount as timed 10/5-yuan ejector pulses with inventory tracking.
// Optional build macro CHANGE_AUDIT_EN adds a saturating audit_total output counting yuan ejected since reset.
module change_dispenser #(
    parameter int AMT_W      = 6,
    parameter int INV_W      = 4,
    parameter int INV10_INIT = 8,
    parameter int INV5_INIT  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AMT_W-1:0] change_in,
    input  logic             change_valid,
    input  logic             refill,
    output logic             payout_coin_10,
    output logic             payout_coin_5,
    output logic             busy,
    output logic             done,
    output logic             bad_amount,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [INV_W-1:0] inv_10,
    output logic [INV_W-1:0] inv_5
`ifdef CHANGE_AUDIT_EN
    ,
    output logic [15:0]      audit_total
`endif
);

    localparam int CW    = AMT_W + INV_W;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [AMT_W-1:0] AMT_5   = AMT_W'(5);
    localparam logic [AMT_W-1:0] AMT_10  = AMT_W'(10);
    localparam logic [CW-1:0]    CW_5    = CW'(5);
    localparam logic [CW-1:0]    CW_10   = CW'(10);
    localparam logic [INV_W-1:0] INV_ONE = INV_W'(1);
    localparam logic [INV_W-1:0] INV10_R = INV_W'(INV10_INIT);
    localparam logic [INV_W-1:0] INV5_R  = INV_W'(INV5_INIT);
    localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_EJECT,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [AMT_W-1:0]   rem_q, rem_d;
    logic [INV_W-1:0]   inv10_q, inv10_d;
    logic [INV_W-1:0]   inv5_q, inv5_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               zero_done_q, zero_done_d;
    logic               bad_q, bad_d;

    // Feasibility test: take as many tens as possible, then fives must cover the rest.
    logic [CW-1:0]      rem_ext;
    logic [CW-1:0]      tens_wanted;
    logic [CW-1:0]      tens_used;
    logic [CW-1:0]      rest_after_tens;
    logic [CW-1:0]      fives_needed;
    logic               check_ok;
    logic               use_ten;

    always_comb begin
        rem_ext         = CW'(rem_q);
        tens_wanted     = rem_ext / CW_10;
        tens_used       = (tens_wanted < CW'(inv10_q)) ? tens_wanted : CW'(inv10_q);
        rest_after_tens = rem_ext - (tens_used * CW_10);
        fives_needed    = rest_after_tens / CW_5;
        check_ok        = (fives_needed <= CW'(inv5_q));
        use_ten         = (rem_q >= AMT_10) && (inv10_q != '0);
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        inv10_d     = inv10_q;
        inv5_d      = inv5_q;
        gap_d       = gap_q;
        zero_done_d = 1'b0;
        bad_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Refill lands in the same edge as the latch, so CHECK sees the new inventory.
                if (refill) begin
                    inv10_d = INV10_R;
                    inv5_d  = INV5_R;
                end
                if (change_valid) begin
                    if (change_in == '0) begin
                        zero_done_d = 1'b1;
                    end else if ((change_in % AMT_5) != '0) begin
                        bad_d = 1'b1;
                    end else begin
                        rem_d   = change_in;
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                state_d = check_ok ? S_EJECT : S_FAULT;
            end
            S_EJECT: begin
                if (use_ten) begin
                    rem_d   = rem_q - AMT_10;
                    inv10_d = inv10_q - INV_ONE;
                end else begin
                    rem_d  = rem_q - AMT_5;
                    inv5_d = inv5_q - INV_ONE;
                end
                gap_d   = GAP_LD;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = (rem_q != '0) ? S_EJECT : S_DONE;
                end else begin
                    gap_d = gap_q - GAP_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (refill) begin
                    inv10_d = INV10_R;
                    inv5_d  = INV5_R;
                    state_d = S_CHECK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            inv10_q     <= INV10_R;
            inv5_q      <= INV5_R;
            gap_q       <= '0;
            zero_done_q <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            inv10_q     <= inv10_d;
            inv5_q      <= inv5_d;
            gap_q       <= gap_d;
            zero_done_q <= zero_done_d;
            bad_q       <= bad_d;
        end
    end

    assign payout_coin_10 = (state_q == S_EJECT) && use_ten;
    assign payout_coin_5  = (state_q == S_EJECT) && !use_ten;
    assign busy           = (state_q == S_CHECK) || (state_q == S_EJECT) ||
                            (state_q == S_GAP)   || (state_q == S_FAULT);
    assign done           = (state_q == S_DONE) || zero_done_q;
    assign bad_amount     = bad_q;
    assign fault          = (state_q == S_FAULT);
    assign remaining      = rem_q;
    assign inv_10         = inv10_q;
    assign inv_5          = inv5_q;

`ifdef CHANGE_AUDIT_EN
    logic [15:0] audit_q, audit_d;
    logic [16:0] audit_sum;

    always_comb begin
        audit_sum = {1'b0, audit_q};
        if (payout_coin_10) begin
            audit_sum = {1'b0, audit_q} + 17'd10;
        end else if (payout_coin_5) begin
            audit_sum = {1'b0, audit_q} + 17'd5;
        end
        audit_d = audit_sum[16] ? 16'hFFFF : audit_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            audit_q <= '0;
        end else begin
            audit_q <= audit_d;
        end
    end

    assign audit_total = audit_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed vector table, hand-written reset/ignore sequences, then randomized loads vs a payout model.
module tb_change_dispenser;

    localparam int AMT_W = 6;
    localparam int INV_W = 4;
    localparam int I10   = 8;
    localparam int I5    = 8;
    localparam int G     = 2;
    localparam int P     = G + 1;

    localparam int M_PAY   = 0;
    localparam int M_ZERO  = 1;
    localparam int M_BAD   = 2;
    localparam int M_FAULT = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [AMT_W-1:0] change_in;
    logic             change_valid;
    logic             refill;
    logic             payout_coin_10;
    logic             payout_coin_5;
    logic             busy;
    logic             done;
    logic             bad_amount;
    logic             fault;
    logic [AMT_W-1:0] remaining;
    logic [INV_W-1:0] inv_10;
    logic [INV_W-1:0] inv_5;
`ifdef CHANGE_AUDIT_EN
    logic [15:0]      audit_total;
`endif

    change_dispenser #(
        .AMT_W(AMT_W), .INV_W(INV_W), .INV10_INIT(I10), .INV5_INIT(I5), .GAP_CYCLES(G)
    ) dut (
        .clk(clk),
        .rst(rst),
        .change_in(change_in),
        .change_valid(change_valid),
        .refill(refill),
        .payout_coin_10(payout_coin_10),
        .payout_coin_5(payout_coin_5),
        .busy(busy),
        .done(done),
        .bad_amount(bad_amount),
        .fault(fault),
        .remaining(remaining),
        .inv_10(inv_10),
        .inv_5(inv_5)
`ifdef CHANGE_AUDIT_EN
        ,
        .audit_total(audit_total)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int m_inv10, m_inv5, m_audit, m_rem;

    typedef struct {
        bit cv;
        bit rf;
        int amt;
        int mode;
        int n10;
        int n5;
        int inv10;
        int inv5;
        int rem;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > 65535) ? 65535 : a + b;
    endfunction

    // Payout plan from the pay-out rule: greedy tens up to stock, fives must cover the remainder.
    function automatic void plan(input int amt, input int i10, input int i5,
                                 output int n10, output int n5, output bit flt);
        n10 = (amt / 10 < i10) ? amt / 10 : i10;
        n5  = (amt - 10 * n10) / 5;
        flt = (n5 > i5);
    endfunction

    // Expected bits per cycle: {coin10, coin5, done, busy, bad_amount, fault}
    task automatic run_txn(input bit cv, input bit rf, input int amt, input int mode,
                           input int n10, input int n5, input int e_inv10, input int e_inv5,
                           input int e_rem, input int inj, input string name);
        int n, d, last, exp_v, act_v;
        n = n10 + n5;
        case (mode)
            M_PAY:   d = 2 + n * P;
            M_FAULT: d = 2;
            default: d = 1;
        endcase
        last = (mode == M_FAULT) ? d + 4 : d + 1;
        change_in    = AMT_W'(amt);
        change_valid = cv;
        refill       = rf;
        for (int c = 1; c <= last; c++) begin
            tick();
            if (c == 1) begin
                change_valid = 1'b0;
                refill       = 1'b0;
            end
            exp_v = 0;
            case (mode)
                M_PAY: begin
                    if (c >= 2 && (c - 2) % P == 0 && (c - 2) / P < n)
                        exp_v |= ((c - 2) / P < n10) ? 32 : 16;
                    if (c == d) exp_v |= 8;
                    if (c < d)  exp_v |= 4;
                end
                M_ZERO:  exp_v = (c == 1) ? 8 : 0;
                M_BAD:   exp_v = (c == 1) ? 2 : 0;
                default: exp_v = (c == 1) ? 4 : 5;
            endcase
            act_v = {26'd0, payout_coin_10, payout_coin_5, done, busy, bad_amount, fault};
            check($sformatf("%s cycle %0d outputs", name, c), act_v, exp_v);
            if (inj != 0 && c == inj) begin
                change_in    = AMT_W'(30);
                change_valid = 1'b1;
                refill       = 1'b1;
            end
            if (inj != 0 && c == inj + 1) begin
                change_valid = 1'b0;
                refill       = 1'b0;
            end
        end
        check($sformatf("%s inv_10", name), int'(inv_10), e_inv10);
        check($sformatf("%s inv_5", name), int'(inv_5), e_inv5);
        check($sformatf("%s remaining", name), int'(remaining), e_rem);
`ifdef CHANGE_AUDIT_EN
        check($sformatf("%s audit_total", name), int'(audit_total), m_audit);
`endif
        $display("[TB] %s amt=%0d mode=%0d n10=%0d n5=%0d inv=%0d/%0d rem=%0d", name, amt, mode,
                 n10, n5, int'(inv_10), int'(inv_5), int'(remaining));
    endtask

    task automatic do_refill_idle(input string name);
        refill = 1'b1;
        tick();
        refill  = 1'b0;
        m_inv10 = I10;
        m_inv5  = I5;
        check($sformatf("%s inv_10", name), int'(inv_10), I10);
        check($sformatf("%s inv_5", name), int'(inv_5), I5);
        check($sformatf("%s busy", name), int'(busy), 0);
        $display("[TB] %s inv=%0d/%0d", name, int'(inv_10), int'(inv_5));
    endtask

    initial begin
        int amt, mode, n10, n5, e_rem;
        bit rf, flt;

        tbl[0] = '{1'b1, 1'b0, 15, M_PAY,   1, 1, 7, 7, 0};
        tbl[1] = '{1'b1, 1'b0, 0,  M_ZERO,  0, 0, 7, 7, 0};
        tbl[2] = '{1'b1, 1'b0, 7,  M_BAD,   0, 0, 7, 7, 0};
        tbl[3] = '{1'b1, 1'b1, 60, M_PAY,   6, 0, 2, 8, 0};
        tbl[4] = '{1'b1, 1'b0, 60, M_PAY,   2, 8, 0, 0, 0};
        tbl[5] = '{1'b1, 1'b0, 60, M_FAULT, 0, 0, 0, 0, 60};
        tbl[6] = '{1'b0, 1'b1, 60, M_PAY,   6, 0, 2, 8, 0};

        rst          = 1'b1;
        change_in    = '0;
        change_valid = 1'b0;
        refill       = 1'b0;
        tick();
        tick();
        check("reset outputs",
              {26'd0, payout_coin_10, payout_coin_5, done, busy, bad_amount, fault}, 0);
        check("reset remaining", int'(remaining), 0);
        check("reset inv_10", int'(inv_10), I10);
        check("reset inv_5", int'(inv_5), I5);
`ifdef CHANGE_AUDIT_EN
        check("reset audit_total", int'(audit_total), 0);
`endif
        rst = 1'b0;
        tick();
        m_inv10 = I10;
        m_inv5  = I5;
        m_audit = 0;
        m_rem   = 0;

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].mode == M_PAY)
                m_audit = sat_add(m_audit, 10 * tbl[i].n10 + 5 * tbl[i].n5);
            run_txn(tbl[i].cv, tbl[i].rf, tbl[i].amt, tbl[i].mode, tbl[i].n10, tbl[i].n5,
                    tbl[i].inv10, tbl[i].inv5, tbl[i].rem, 0, $sformatf("vec%0d", i));
        end

        // change_valid and refill asserted during GAP must not disturb the payout in flight
        do_refill_idle("refill_idle");
        m_audit = sat_add(m_audit, 40);
        run_txn(1'b1, 1'b0, 40, M_PAY, 4, 0, 4, 8, 0, 3, "gap_ignore");

        // asynchronous reset in the middle of a GAP aborts the payout
        do_refill_idle("refill_pre_reset");
        change_in    = AMT_W'(40);
        change_valid = 1'b1;
        tick();
        change_valid = 1'b0;
        tick();
        check("rst_seq first pulse", int'(payout_coin_10), 1);
        tick();
        check("rst_seq in gap busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        m_audit = 0;
        check("rst_seq remaining", int'(remaining), 0);
        check("rst_seq inv_10", int'(inv_10), I10);
        check("rst_seq inv_5", int'(inv_5), I5);
        check("rst_seq busy", int'(busy), 0);
`ifdef CHANGE_AUDIT_EN
        check("rst_seq audit_total", int'(audit_total), 0);
`endif
        tick();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            check($sformatf("rst_seq quiet cycle %0d", c),
                  {29'd0, payout_coin_10, payout_coin_5, busy}, 0);
        end
        $display("[TB] rst_seq inv=%0d/%0d rem=%0d", int'(inv_10), int'(inv_5), int'(remaining));
        m_inv10 = I10;
        m_inv5  = I5;
        m_rem   = 0;

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) amt = $urandom_range(0, 63);
            else                           amt = 5 * $urandom_range(0, 12);
            rf  = ($urandom_range(0, 4) == 0);
            n10 = 0;
            n5  = 0;
            if (rf) begin
                m_inv10 = I10;
                m_inv5  = I5;
            end
            if (amt == 0) begin
                mode = M_ZERO;
            end else if (amt % 5 != 0) begin
                mode = M_BAD;
            end else begin
                plan(amt, m_inv10, m_inv5, n10, n5, flt);
                if (flt) begin
                    mode  = M_FAULT;
                    m_rem = amt;
                    n10   = 0;
                    n5    = 0;
                end else begin
                    mode    = M_PAY;
                    m_rem   = 0;
                    m_inv10 = m_inv10 - n10;
                    m_inv5  = m_inv5 - n5;
                    m_audit = sat_add(m_audit, 10 * n10 + 5 * n5);
                end
            end
            e_rem = m_rem;
            run_txn(1'b1, rf, amt, mode, n10, n5, m_inv10, m_inv5, e_rem, 0,
                    $sformatf("rand%0d", it));
            if (mode == M_FAULT) begin
                m_inv10 = I10;
                m_inv5  = I5;
                plan(amt, m_inv10, m_inv5, n10, n5, flt);
                m_inv10 = m_inv10 - n10;
                m_inv5  = m_inv5 - n5;
                m_rem   = 0;
                m_audit = sat_add(m_audit, 10 * n10 + 5 * n5);
                run_txn(1'b0, 1'b1, amt, M_PAY, n10, n5, m_inv10, m_inv5, 0, 0,
                        $sformatf("rand%0d_retry", it));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
